md_sched: RTL and testbench

Multiply/divide scheduler for the EX stage. It accepts MULT/MULTU/DIV/DIVU operations from EX and runs them on a shared iterative shift-add/restoring-subtract unit, one bit per cycle. While an operation is in flight it holds EX through the stall controller. On completion it issues a single HI/LO write.

---
 rtl/md_sched.sv | 213 +++++++++++++++++++++
 tb/tb_md_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for the EX stage.
// It runs MULT/MULTU/DIV/DIVU on one shared iterative datapath, one bit
// per cycle (32 iterations). EX is held while an operation is in flight,
// and a single HI/LO write strobe is raised on completion.
module md_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stallreq_ex,
    output logic        busy,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [5:0]  cnt_r;
    logic [63:0] acc_r;        // mul: {partial HI, multiplier}; div: {remainder, quotient}
    logic [31:0] opb_r;        // multiplicand magnitude or divisor magnitude
    logic [31:0] src_a_raw_r;  // dividend as issued, returned unchanged on divide by zero
    logic        is_div_r;
    logic        sign_a_r;     // operand sign bits, already forced to 0 for unsigned ops
    logic        sign_b_r;
    logic        div_zero_r;

    logic        accept_s;
    logic        is_signed_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_rem_s;
    logic [32:0] div_diff_s;
    logic        div_ge_s;
    logic [63:0] acc_nxt_s;
    logic [31:0] fix_hi_s;
    logic [31:0] fix_lo_s;
    logic        stall_req_s;
    logic        hilo_we_s;

    // Magnitude of a 32-bit operand; only negated for signed ops.
    function automatic logic [31:0] mag32(input logic [31:0] val, input logic signed_en);
        if (signed_en && val[31]) begin
            mag32 = (~val) + 32'd1;
        end else begin
            mag32 = val;
        end
    endfunction

    // Two's-complement negation helpers used by the sign fixup.
    function automatic logic [31:0] neg32(input logic [31:0] val);
        neg32 = (~val) + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] val);
        neg64 = (~val) + 64'd1;
    endfunction

    assign accept_s    = (state_r == IDLE) && op_valid && !flush;
    assign is_signed_s = ~op_code[0];
    assign mag_a_s     = mag32(src_a, is_signed_s);
    assign mag_b_s     = mag32(src_b, is_signed_s);

    // One datapath iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opb_r} : 33'd0);
        div_rem_s  = acc_r[63:31];
        div_diff_s = div_rem_s - {1'b0, opb_r};
        div_ge_s   = (div_rem_s >= {1'b0, opb_r});
        acc_nxt_s  = acc_r;
        if (is_div_r) begin
            if (div_ge_s) begin
                acc_nxt_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
            end else begin
                acc_nxt_s = {div_rem_s[31:0], acc_r[30:0], 1'b0};
            end
        end else begin
            acc_nxt_s = {mul_sum_s, acc_r[31:1]};
        end
    end

    // Sign fixup and divide-by-zero substitution on the raw unsigned result.
    always_comb begin
        fix_hi_s = 32'd0;
        fix_lo_s = 32'd0;
        if (!is_div_r) begin
            if (sign_a_r ^ sign_b_r) begin
                {fix_hi_s, fix_lo_s} = neg64(acc_r);
            end else begin
                {fix_hi_s, fix_lo_s} = acc_r;
            end
        end else if (div_zero_r) begin
            fix_hi_s = src_a_raw_r;
            fix_lo_s = 32'hFFFF_FFFF;
        end else begin
            if (sign_a_r ^ sign_b_r) begin
                fix_lo_s = neg32(acc_r[31:0]);
            end else begin
                fix_lo_s = acc_r[31:0];
            end
            if (sign_a_r) begin
                fix_hi_s = neg32(acc_r[63:32]);
            end else begin
                fix_hi_s = acc_r[63:32];
            end
        end
    end

    // Next-state and output decode; flush wins over everything else.
    always_comb begin
        state_nxt_s = state_r;
        stall_req_s = 1'b0;
        hilo_we_s   = 1'b0;
        hi_wdata    = 32'd0;
        lo_wdata    = 32'd0;
        case (state_r)
            IDLE: begin
                if (flush) begin
                    state_nxt_s = IDLE;
                end else if (op_valid) begin
                    state_nxt_s = RUN;
                    stall_req_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt_s = IDLE;
                end else begin
                    stall_req_s = 1'b1;
                    if (cnt_r == 6'd31) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
            end
            DONE: begin
                hi_wdata = fix_hi_s;
                lo_wdata = fix_lo_s;
                if (flush) begin
                    state_nxt_s = IDLE;
                end else if (!stall[3]) begin
                    hilo_we_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // A reset cycle never requests a stall nor commits a write.
    assign stallreq_ex = stall_req_s & ~rst;
    assign hilo_we     = hilo_we_s & ~rst;
    assign busy        = (state_r != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture at acceptance and per-cycle datapath/counter update.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= 6'd0;
            acc_r       <= 64'd0;
            opb_r       <= 32'd0;
            src_a_raw_r <= 32'd0;
            is_div_r    <= 1'b0;
            sign_a_r    <= 1'b0;
            sign_b_r    <= 1'b0;
            div_zero_r  <= 1'b0;
        end else if (accept_s) begin
            cnt_r       <= 6'd0;
            is_div_r    <= op_code[1];
            sign_a_r    <= src_a[31] & is_signed_s;
            sign_b_r    <= src_b[31] & is_signed_s;
            div_zero_r  <= op_code[1] && (src_b == 32'd0);
            src_a_raw_r <= src_a;
            if (op_code[1]) begin
                acc_r <= {32'd0, mag_a_s};
                opb_r <= mag_b_s;
            end else begin
                acc_r <= {32'd0, mag_b_s};
                opb_r <= mag_a_s;
            end
        end else if ((state_r == RUN) && !flush) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r + 6'd1;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Testbench for md_sched: directed and random operations checked against a
// high-level arithmetic model via a result scoreboard.
module tb_md_sched;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stallreq_ex;
    logic        busy;
    logic        hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];

    md_sched dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .src_a      (src_a),
        .src_b      (src_b),
        .stallreq_ex(stallreq_ex),
        .busy       (busy),
        .hilo_we    (hilo_we),
        .hi_wdata   (hi_wdata),
        .lo_wdata   (lo_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference result {HI, LO} straight from the arithmetic definition.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 64'd0;
        case (op)
            2'b00: r = 64'(sa * sb);
            2'b01: r = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // Monitor: every write strobe must match the oldest expected result.
    always @(negedge clk) begin
        if (hilo_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_hilo_we", 64'd1, 64'd0);
            end else begin
                check("hilo_result", {hi_wdata, lo_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, optionally holding EX for 'hold' cycles once DONE is reached.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        int st_cnt;
        int we_cyc;
        tick();
        op_valid = 1'b1;
        op_code  = op;
        src_a    = a;
        src_b    = b;
        stall    = 6'd0;
        exp_q.push_back(model(op, a, b));
        st_cnt = 0;
        we_cyc = -1;
        for (int k = 0; k < 120 && we_cyc < 0; k++) begin
            if (k > 0) begin
                tick();
                op_valid = 1'b0;
                stall    = (k >= 33 && k < 33 + hold) ? 6'b001000 : 6'b000000;
            end
            @(negedge clk);
            if (stallreq_ex) st_cnt++;
            if (hilo_we) we_cyc = k;
        end
        check("hilo_we_cycle", 64'(we_cyc), 64'(33 + hold));
        check("stallreq_len", 64'(st_cnt), 64'd33);
        tick();
        stall = 6'd0;
        @(negedge clk);
        check("busy_after_write", {63'd0, busy}, 64'd0);
    endtask

    // Start an op and abandon it at cycle 'at' using flush or rst.
    task automatic abort_op(input int at, input logic use_rst);
        tick();
        op_valid = 1'b1;
        op_code  = 2'b11;
        src_a    = 32'd1000;
        src_b    = 32'd3;
        for (int k = 1; k <= at; k++) begin
            tick();
            op_valid = 1'b0;
        end
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        @(negedge clk);
        check("abort_stallreq", {63'd0, stallreq_ex}, 64'd0);
        check("abort_hilo_we", {63'd0, hilo_we}, 64'd0);
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("abort_idle", {61'd0, busy, stallreq_ex, hilo_we}, 64'd0);
        check("abort_data", {hi_wdata, lo_wdata}, 64'd0);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        rst      = 1'b1;
        stall    = 6'd0;
        flush    = 1'b0;
        op_valid = 1'b0;
        op_code  = 2'b00;
        src_a    = 32'd0;
        src_b    = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl", {61'd0, busy, stallreq_ex, hilo_we}, 64'd0);
        check("reset_data", {hi_wdata, lo_wdata}, 64'd0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'b11, 32'd100, 32'd0, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b11, 32'd100, 32'd7, 3);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd0, 1);

        // Flush in IDLE overrides op_valid.
        tick();
        op_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        check("idle_flush_stallreq", {63'd0, stallreq_ex}, 64'd0);
        tick();
        op_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check("idle_flush_busy", {63'd0, busy}, 64'd0);

        abort_op(10, 1'b0);
        abort_op(20, 1'b1);
        run_op(2'b11, 32'd100, 32'd7, 0);

        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = $urandom;
            if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) r_b = 32'd0;
            run_op(r_op, r_a, r_b, int'($urandom_range(0, 2)));
        end

        tick();
        tick();
        check("pending_results", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
